spike_rate_encoder: RTL and testbench

//  Input stage of the IF spiking network.
//  - Converts one sample of NUM_INPUTS unsigned intensities into NUM_TIMESTEPS cycles of spike trains.
//  - Uses deterministic phase-accumulator rate coding.
//  - spike_out drives if_network spike_in directly: one bit per input channel, one timestep per clock.

---
 rtl/spike_rate_encoder_if.sv | 24 ++
 rtl/spike_rate_encoder.sv | 106 ++++++++++
 tb/tb_spike_rate_encoder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_encoder_if.sv
// Sample-in / spike-train-out bundle for the rate encoder.
// The master side offers samples and observes spikes; the slave is the encoder.
interface spike_rate_encoder_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]            spike_out;
    logic                             spike_valid;
    logic                             busy;
    logic                             done;

    modport master (
        output in_valid, in_data,
        input  in_ready, spike_out, spike_valid, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, spike_out, spike_valid, busy, done
    );
endinterface

// File: rtl/spike_rate_encoder.sv
// Deterministic phase-accumulator rate coder: one sample of intensities
// becomes NUM_TIMESTEPS cycles of per-channel spikes for the IF network.
module spike_rate_encoder #(
    parameter int NUM_INPUTS    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_TIMESTEPS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    spike_rate_encoder_if.slave  bus
);
    localparam int TW = $clog2(NUM_TIMESTEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_acc [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] r_int [NUM_INPUTS];
    logic [DATA_WIDTH:0]   w_sum [NUM_INPUTS];
    logic [TW-1:0]         r_tcnt;
    logic [NUM_INPUTS-1:0] r_spike;
    logic                  r_valid;
    logic                  r_done;
    logic                  w_last;

    assign w_last = (r_tcnt == TW'(NUM_TIMESTEPS - 1));

    // The carry out of each accumulator is that channel's spike.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_int[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clear) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_acc[i] <= '0;
                r_int[i] <= '0;
            end
            r_tcnt  <= '0;
            r_spike <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (clear) begin
            r_spike <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            r_int[i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                            r_acc[i] <= '0;
                        end
                        r_tcnt <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        r_acc[i]   <= w_sum[i][DATA_WIDTH-1:0];
                        r_spike[i] <= w_sum[i][DATA_WIDTH];
                    end
                    r_valid <= 1'b1;
                    r_tcnt  <= r_tcnt + TW'(1);
                end
                S_DONE: begin
                    r_spike <= '0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.spike_out   = r_spike;
    assign bus.spike_valid = r_valid;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: timeline model with closed-form spike
// times checked every cycle, plus directed literal scenarios.
module tb_spike_rate_encoder;
    localparam int NI = 4;
    localparam int DW = 8;
    localparam int NT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;

    spike_rate_encoder_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) u_if ();

    spike_rate_encoder #(
        .NUM_INPUTS(NI),
        .DATA_WIDTH(DW),
        .NUM_TIMESTEPS(NT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .bus(u_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp,
                     $time);
        end
    endtask

    // Timestep t spikes when floor(t*I/2^DW) steps up from t-1.
    function automatic logic sp(input int t, input int iv);
        return ((t * iv) >> DW) > (((t - 1) * iv) >> DW);
    endfunction

    // Model: m_t counts edges since the accepted handshake.
    bit m_act;
    bit m_done;
    int m_t;
    int m_int [NI];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_t    = 0;
        end else if (clear) begin
            m_act  = 1'b0;
            m_done = 1'b0;
        end else if (!m_act) begin
            m_done = 1'b0;
            if (u_if.in_valid) begin
                m_act = 1'b1;
                m_t   = 0;
                for (int i = 0; i < NI; i++)
                    m_int[i] = int'(u_if.in_data[i*DW +: DW]);
            end
        end else begin
            m_t++;
            if (m_t == NT + 1) begin
                m_act  = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    int            h_ts;
    int            h_cnt  [NI];
    logic [NT-1:0] h_mask [NI];
    logic [NI-1:0] e_spk;
    bit            e_val;

    always @(negedge clk) begin
        if (rst) begin
            e_val = m_act && m_t >= 1 && m_t <= NT;
            e_spk = '0;
            if (e_val)
                for (int i = 0; i < NI; i++) e_spk[i] = sp(m_t, m_int[i]);
            chk("in_ready", 32'(u_if.in_ready), 32'(!m_act));
            chk("busy", 32'(u_if.busy), 32'(m_act));
            chk("spike_valid", 32'(u_if.spike_valid), 32'(e_val));
            chk("spike_out", 32'(u_if.spike_out), 32'(e_spk));
            chk("done", 32'(u_if.done), 32'(m_done));
            if (u_if.spike_valid === 1'b1) begin
                h_ts++;
                for (int i = 0; i < NI; i++) begin
                    if (u_if.spike_out[i] === 1'b1) begin
                        h_cnt[i]++;
                        if (h_ts <= NT) h_mask[i][h_ts-1] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic clr_hist();
        h_ts = 0;
        for (int i = 0; i < NI; i++) begin
            h_cnt[i]  = 0;
            h_mask[i] = '0;
        end
    endtask

    task automatic send(input logic [31:0] d);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        clr_hist();
        #1;
        chk("rst_spike_out", 32'(u_if.spike_out), 32'd0);
        chk("rst_valid", 32'(u_if.spike_valid), 32'd0);
        chk("rst_done", 32'(u_if.done), 32'd0);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        edges(3);
        rst = 1'b1;
        chk("rst_ready", 32'(u_if.in_ready), 32'd1);

        // Single sample ch0..ch3 = 0,16,128,255 with explicit latency.
        clr_hist();
        send(32'hFF80_1000);
        for (int j = 0; j <= NT + 1; j++) begin
            @(negedge clk);
            chk("lat_valid", 32'(u_if.spike_valid),
                32'(j >= 1 && j <= NT));
            if (j <= NT) chk("lat_ready", 32'(u_if.in_ready), 32'd0);
            chk("lat_done", 32'(u_if.done), 32'(j == NT + 1));
        end
        chk("cnt_ch0", h_cnt[0], 0);
        chk("cnt_ch1", h_cnt[1], 1);
        chk("cnt_ch2", h_cnt[2], 8);
        chk("cnt_ch3", h_cnt[3], 15);
        chk("mask_ch1", 32'(h_mask[1]), 32'h8000);
        chk("mask_ch2", 32'(h_mask[2]), 32'hAAAA);
        chk("mask_ch3", 32'(h_mask[3]), 32'hFFFE);
        chk("ts_total", h_ts, NT);

        // in_valid held with new data during RUN.
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 32'h4040_4040;
        edges(1);
        u_if.in_data = 32'hC864_3201;
        clr_hist();
        edges(17);
        chk("hold_done_ready", 32'(u_if.in_ready), 32'd1);
        chk("hold_done_busy", 32'(u_if.busy), 32'd0);
        chk("hold_a_ts", h_ts, NT);
        for (int i = 0; i < NI; i++) chk("hold_a_cnt", h_cnt[i], 4);
        clr_hist();
        edges(1);
        u_if.in_valid = 1'b0;
        chk("hold_b_accepted", 32'(u_if.busy), 32'd1);
        edges(17);
        chk("hold_b_ts", h_ts, NT);
        chk("hold_b_ch0", h_cnt[0], 0);
        chk("hold_b_ch1", h_cnt[1], 3);
        chk("hold_b_ch2", h_cnt[2], 6);
        chk("hold_b_ch3", h_cnt[3], 12);

        // clear at timestep 5.
        clr_hist();
        send(32'hFFFF_FFFF);
        for (int n = 0; n < 40 && h_ts < 5; n++) begin
            @(negedge clk);
            #1;
        end
        chk("clr_reach_ts5", h_ts, 5);
        clear = 1'b1;
        edges(1);
        clear = 1'b0;
        chk("clr_valid", 32'(u_if.spike_valid), 32'd0);
        chk("clr_spike", 32'(u_if.spike_out), 32'd0);
        chk("clr_busy", 32'(u_if.busy), 32'd0);
        chk("clr_ready", 32'(u_if.in_ready), 32'd1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("clr_no_done", 32'(u_if.done), 32'd0);
        end
        chk("clr_partial_cnt", h_cnt[3], 4);
        clr_hist();
        send(32'hFFFF_FFFF);
        edges(17);
        chk("clr_next_ts", h_ts, NT);
        for (int i = 0; i < NI; i++) chk("clr_next_cnt", h_cnt[i], 15);

        // clear beats a handshake.
        @(posedge clk);
        #1;
        clear = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 32'h1111_1111;
        edges(1);
        clear = 1'b0;
        u_if.in_valid = 1'b0;
        chk("clr_hs_busy", 32'(u_if.busy), 32'd0);

        // clear beats the done pulse.
        send(32'h2020_2020);
        edges(16);
        chk("clr_dn_state", 32'(u_if.busy), 32'd1);
        clear = 1'b1;
        edges(1);
        clear = 1'b0;
        chk("clr_dn_done", 32'(u_if.done), 32'd0);
        chk("clr_dn_ready", 32'(u_if.in_ready), 32'd1);

        // async reset mid-RUN.
        send(32'h8080_8080);
        repeat (4) @(posedge clk);
        #2;
        chk("mid_valid_pre", 32'(u_if.spike_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(u_if.spike_valid), 32'd0);
        chk("arst_spike", 32'(u_if.spike_out), 32'd0);
        chk("arst_busy", 32'(u_if.busy), 32'd0);
        chk("arst_done", 32'(u_if.done), 32'd0);
        edges(1);
        rst = 1'b1;
        chk("arst_ready", 32'(u_if.in_ready), 32'd1);
        edges(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end
endmodule
